// File: rtl/fifo_pkg.sv
// Shared helpers and types for the fifo_v2 family: pointer sizing, wrap-around
// increment for arbitrary depths, and a bundled status record.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
        logic ovf;
        logic udf;
    } fifo_status_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Explicit compare so non-power-of-two depths wrap correctly.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer register used for both the read and write side of fifo_v2.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = PTR_W'(next_ptr(32'(ptr_q), DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_v2.sv
// Synchronous FIFO with arbitrary depth, optional fall-through, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_v2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int FALL_THROUGH = 0,
    parameter int AFULL_THR    = DEPTH - 1,
    parameter int AEMPTY_THR   = 1,
    parameter int PTR_W        = ptr_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [PTR_W:0]        cnt_o,
    output logic                  ovf_o,
    output logic                  udf_o
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("fifo_v2: DEPTH must be >= 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("fifo_v2: DATA_WIDTH must be >= 1");
    end
    if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_afull
        $error("fifo_v2: AFULL_THR out of range 1..DEPTH");
    end
    if (AEMPTY_THR < 0 || AEMPTY_THR > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_v2: AEMPTY_THR out of range 0..DEPTH-1");
    end

    localparam bit           FT       = (FALL_THROUGH != 0);
    localparam logic [PTR_W:0] DEPTH_C  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AFULL_C  = (PTR_W+1)'(AFULL_THR);
    localparam logic [PTR_W:0] AEMPTY_C = (PTR_W+1)'(AEMPTY_THR);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]        count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;

    logic cnt_zero, full, bypass, push_acc, wr_en, rd_en;

    always_comb begin
        cnt_zero = (count_q == '0);
        full     = (count_q == DEPTH_C);
        // Fall-through with push and pop on an empty FIFO hands dat_i straight out.
        bypass   = FT && cnt_zero && push_i && pop_i;
        empty_o  = (FT && cnt_zero) ? ~push_i : cnt_zero;
        push_acc = push_i & ~full;
        wr_en    = push_acc & ~bypass & ~flush_i;
        rd_en    = pop_i & ~cnt_zero & ~flush_i;
    end

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q | (push_i & full);
        udf_d   = udf_q | (pop_i & empty_o);
        if (flush_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately left unreset; contents are meaningless while empty.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            mem_q[wr_ptr] <= dat_i;
        end
    end

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (flush_i),
        .inc   (wr_en),
        .ptr   (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (flush_i),
        .inc   (rd_en),
        .ptr   (rd_ptr)
    );

    assign dat_o          = (FT && cnt_zero) ? dat_i : mem_q[rd_ptr];
    assign full_o         = full;
    assign almost_full_o  = (count_q >= AFULL_C);
    assign almost_empty_o = (count_q <= AEMPTY_C);
    assign cnt_o          = count_q;
    assign ovf_o          = ovf_q;
    assign udf_o          = udf_q;

endmodule

// File: tb/tb_fifo_v2.sv
// Directed bench for fifo_v2: a registered-output instance (DEPTH=5) and a
// fall-through instance sharing clock and reset.
module tb_fifo_v2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    logic       fl0, pu0, po0;
    logic [7:0] di0, do0;
    logic       f0, e0, af0, ae0, ov0, ud0;
    logic [3:0] c0;

    logic       fl1, pu1, po1;
    logic [7:0] di1, do1;
    logic       f1, e1, af1, ae1, ov1, ud1;
    logic [3:0] c1;

    fifo_v2 #(.DATA_WIDTH(8), .DEPTH(5), .FALL_THROUGH(0), .AFULL_THR(4), .AEMPTY_THR(1)) u_ft0 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl0), .dat_i(di0), .push_i(pu0), .pop_i(po0),
        .dat_o(do0), .full_o(f0), .empty_o(e0), .almost_full_o(af0), .almost_empty_o(ae0),
        .cnt_o(c0), .ovf_o(ov0), .udf_o(ud0)
    );

    fifo_v2 #(.DATA_WIDTH(8), .DEPTH(5), .FALL_THROUGH(1), .AFULL_THR(4), .AEMPTY_THR(1)) u_ft1 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl1), .dat_i(di1), .push_i(pu1), .pop_i(po1),
        .dat_o(do1), .full_o(f1), .empty_o(e1), .almost_full_o(af1), .almost_empty_o(ae1),
        .cnt_o(c1), .ovf_o(ov1), .udf_o(ud1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] d);
        pu0 = 1'b1; di0 = d;
        tick();
        pu0 = 1'b0;
    endtask

    task automatic pop0(input string tag, input logic [7:0] exp);
        chk(tag, do0, exp);
        po0 = 1'b1;
        tick();
        po0 = 1'b0;
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_empty"}, e0, 1'b1);
        chk({tag, "_full"}, f0, 1'b0);
        chk({tag, "_cnt"}, c0, 4'd0);
        chk({tag, "_ae"}, ae0, 1'b1);
        chk({tag, "_af"}, af0, 1'b0);
        chk({tag, "_ovf"}, ov0, 1'b0);
        chk({tag, "_udf"}, ud0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        fl0 = 0; pu0 = 0; po0 = 0; di0 = '0;
        fl1 = 0; pu1 = 0; po1 = 0; di1 = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset0("rst");

        // Fill to full, watching thresholds along the way.
        push0(8'h01);
        chk("p1_cnt", c0, 4'd1);
        chk("p1_empty", e0, 1'b0);
        chk("p1_dat", do0, 8'h01);
        chk("p1_ae", ae0, 1'b1);
        push0(8'h02);
        chk("p2_ae", ae0, 1'b0);
        chk("p2_af", af0, 1'b0);
        push0(8'h03);
        push0(8'h04);
        chk("p4_af", af0, 1'b1);
        chk("p4_full", f0, 1'b0);
        push0(8'h05);
        chk("p5_full", f0, 1'b1);
        chk("p5_cnt", c0, 4'd5);
        chk("p5_af", af0, 1'b1);
        push0(8'h06);
        chk("p6_ovf", ov0, 1'b1);
        chk("p6_cnt", c0, 4'd5);

        pop0("pop1", 8'h01);
        pop0("pop2", 8'h02);
        pop0("pop3", 8'h03);
        pop0("pop4", 8'h04);
        pop0("pop5", 8'h05);
        chk("drain_empty", e0, 1'b1);
        chk("drain_udf", ud0, 1'b0);

        fl0 = 1'b1;
        tick();
        fl0 = 1'b0;
        chk("fl_ovf", ov0, 1'b0);
        chk("fl_cnt", c0, 4'd0);

        // Advance pointers to 3 so the next five pushes wrap 4->0.
        push0(8'h11); push0(8'h12); push0(8'h13);
        pop0("pre1", 8'h11); pop0("pre2", 8'h12); pop0("pre3", 8'h13);
        push0(8'hA0); push0(8'hA1); push0(8'hA2); push0(8'hA3); push0(8'hA4);
        chk("wrap_full", f0, 1'b1);

        // Push+pop while full: pop wins, push is rejected.
        pu0 = 1'b1; po0 = 1'b1; di0 = 8'hFF;
        chk("fpp_head", do0, 8'hA0);
        tick();
        pu0 = 1'b0; po0 = 1'b0;
        chk("fpp_cnt", c0, 4'd4);
        chk("fpp_ovf", ov0, 1'b1);
        chk("fpp_full", f0, 1'b0);
        pop0("wpop1", 8'hA1);
        pop0("wpop2", 8'hA2);
        pop0("wpop3", 8'hA3);
        pop0("wpop4", 8'hA4);
        chk("wrap_empty", e0, 1'b1);

        // Push+pop while empty without fall-through: pop rejected, push stored.
        pu0 = 1'b1; po0 = 1'b1; di0 = 8'h77;
        tick();
        pu0 = 1'b0; po0 = 1'b0;
        chk("epp_udf", ud0, 1'b1);
        chk("epp_cnt", c0, 4'd1);
        chk("epp_dat", do0, 8'h77);

        push0(8'h78); push0(8'h79);
        chk("pre_fl_cnt", c0, 4'd3);
        fl0 = 1'b1; pu0 = 1'b1; di0 = 8'hAA;
        tick();
        fl0 = 1'b0; pu0 = 1'b0;
        chk("flp_cnt", c0, 4'd0);
        chk("flp_empty", e0, 1'b1);
        chk("flp_ovf", ov0, 1'b0);
        chk("flp_udf", ud0, 1'b0);

        // Reset in the middle of a burst discards everything.
        push0(8'h01); push0(8'h02);
        pu0 = 1'b1; po0 = 1'b1; di0 = 8'h03; rst = 1'b1;
        tick();
        rst = 1'b0; pu0 = 1'b0; po0 = 1'b0;
        chk_reset0("mrst");

        // Fall-through instance.
        chk("ft_rst_empty", e1, 1'b1);
        pu1 = 1'b1; po1 = 1'b1; di1 = 8'h5A;
        #1;
        chk("ft_byp_dat", do1, 8'h5A);
        chk("ft_byp_empty", e1, 1'b0);
        tick();
        pu1 = 1'b0; po1 = 1'b0;
        #1;
        chk("ft_byp_cnt", c1, 4'd0);
        chk("ft_byp_udf", ud1, 1'b0);
        chk("ft_byp_empty2", e1, 1'b1);
        pu1 = 1'b1; di1 = 8'h33;
        #1;
        chk("ft_push_dat", do1, 8'h33);
        chk("ft_push_empty", e1, 1'b0);
        tick();
        pu1 = 1'b0;
        #1;
        chk("ft_push_cnt", c1, 4'd1);
        chk("ft_push_dat2", do1, 8'h33);
        chk("ft_push_empty2", e1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_v2.md
Name: fifo_v2

Overview:
- Parametrised synchronous FIFO, next generation of the team's register-based FIFO.
- Adds the following:
  - arbitrary (non-power-of-two) depth with explicit pointer wrap
  - optional fall-through (zero-latency) mode
  - programmable almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags
- Used as the standard buffer between peripheral data paths and bus/DMA logic; single clock domain.

Parameters:
- DATA_WIDTH, 32, width of each stored word; must be ≥1.
- DEPTH, 8, number of entries; any integer ≥1, not restricted to 2^n.
- FALL_THROUGH, 0, 1 = a push into an empty FIFO is visible on dat_o in the same cycle.
- AFULL_THR, DEPTH-1, almost_full_o asserts when count ≥ this value; legal range 1..DEPTH.
- AEMPTY_THR, 1, almost_empty_o asserts when count ≤ this value; legal range 0..DEPTH-1.
- PTR_W, (DEPTH>1)?$clog2(DEPTH):1, derived pointer width; do not override.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  synchronous clear of contents and error flags.
- dat_i  in  DATA_WIDTH  push data.
- push_i  in  1  push request.
- pop_i  in  1  pop request.
- dat_o  out  DATA_WIDTH  head-of-queue data; valid only while empty_o=0.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  no data available (see fall-through rule).
- almost_full_o  out  1  count ≥ AFULL_THR.
- almost_empty_o  out  1  count ≤ AEMPTY_THR.
- cnt_o  out  PTR_W+1  current stored-entry count.
- ovf_o  out  1  sticky: a push was attempted while full.
- udf_o  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - rd_ptr, wr_ptr and count go to 0; ovf_o and udf_o go to 0.
  - Outputs after reset: empty_o=1, full_o=0, cnt_o=0, almost_empty_o=1, almost_full_o=0.
  - Storage is not reset; dat_o is don't-care while empty.
  - Reset overrides flush, push and pop in the same cycle, including mid-operation; all in-flight data is discarded.
- Handshakes:
  - push_acc = push_i & ~full_o
  - pop_acc = pop_i & ~empty_o
  - A rejected request has no effect other than setting the error flags.
- Pointers: on an accepted operation, increment; when the pointer equals DEPTH-1 the next value is 0 (explicit compare, no power-of-two masking).
- Count:
  - push_acc only → +1.
  - pop_acc only → -1.
  - both → unchanged; the read and the write both happen.
- Simultaneous push and pop when full: the pop is accepted, the push is rejected (full_o is registered state) and ovf_o sets.
- Simultaneous push and pop when count=0, FALL_THROUGH=0: the pop is rejected and udf_o sets; the push is stored.
- FALL_THROUGH=1 when count=0:
  - empty_o = ~push_i and dat_o = dat_i.
  - If push_i and pop_i are both 1, the word bypasses storage; pointers and count are unchanged; no udf.
  - If only push_i is 1, the word is stored normally.
- Latency:
  - FALL_THROUGH=0: a word pushed at edge N appears on dat_o and empty_o falls after edge N.
  - FALL_THROUGH=1: the word is visible combinationally in the same cycle.
  - full_o, almost_* and cnt_o derive from the registered count only (no combinational path from push_i or pop_i).
- Flush (flush_i=1, rst_i=0): next state equals the reset state; the push and pop in that cycle are ignored and do not set error flags.
- Error flags: ovf_o sets on push_i & full_o; udf_o sets on pop_i & empty_o. They clear only on rst_i or flush_i.
- DEPTH=1: PTR_W=1 and the pointer stays 0; full and empty alternate.
- Elaboration: illegal thresholds or DEPTH<1 must stop elaboration with $error.

Decomposition:
- Package fifo_pkg holds:
  - the ptr_width(depth) function
  - the next_ptr wrap helper
  - the fifo_status_t struct (full, empty, afull, aempty, ovf, udf), for consumers that bundle the status signals.
- One sub-module, fifo_wrap_ptr (parameter DEPTH; inputs clr, inc; output ptr), instantiated for the read and write pointers.
- Storage is an inline register array with write enable push_acc and exclusion of the bypass case.

Test Plan:
- DEPTH=5, DW=8: reset, push 0x01..0x05 → full_o=1 and cnt_o=5 after the 5th edge. A 6th push → ovf_o=1 and cnt_o stays 5. Pop 5 → data 0x01..0x05 in order, then empty_o=1.
- DEPTH=5, wrap: push 3 and pop 3, then push 0xA0..0xA4 → wr_ptr wraps 4→0; pops return 0xA0..0xA4 in order.
- Full with push_i=pop_i=1 for one cycle → pop gets the head, cnt_o goes 5→4, ovf_o=1. Empty with push and pop, FT=0 → udf_o=1, cnt_o goes 0→1.
- FALL_THROUGH=1, empty, push_i=pop_i=1 with dat_i=0x5A → dat_o=0x5A and empty_o=0 in the same cycle; cnt_o stays 0; no udf.
- AFULL_THR=4, AEMPTY_THR=1 → almost_empty_o=1 at counts 0–1 and 0 at count 2; almost_full_o=1 at counts 4–5.
- With 3 entries, assert flush_i together with push_i → cnt_o=0 and empty_o=1 next cycle, flags cleared. Assert rst_i mid-burst → all outputs at reset values after the edge.
